// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared widths, port ids and return-tag type for the SRAM arbiter slice
package uc_pkg;

    localparam int UC_ADDR_W = 8;
    localparam int UC_DATA_W = 8;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    localparam logic [7:0] UC_PROT_BASE = 8'hF0;

    typedef struct packed {
        logic valid;
        logic owner;
    } rtag_t;

endpackage

// File: rtl/sram_arb_rpipe.sv
// rtl/sram_arb_rpipe.sv - RD_LAT-deep {valid, owner} tag delay line for SRAM read returns
module sram_arb_rpipe
    import uc_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic  clk,
    input  logic  arst_n,
    input  rtag_t tag_in,
    output rtag_t tag_out
);

    rtag_t stage [RD_LAT];

    // Shift tags forward one stage per cycle; reset drops every in-flight tag
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Last stage lines up with the cycle in which sram_rdata is valid
    assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin CPU/HOST arbiter for the 256x8 data SRAM (option: SRAM_ARB_WPROT_EN)
module sram_arbiter
    import uc_pkg::*;
#(
    parameter int ADDR_W = UC_ADDR_W,
    parameter int DATA_W = UC_DATA_W,
    parameter int RD_LAT = 1
`ifdef SRAM_ARB_WPROT_EN
    ,
    parameter logic [ADDR_W-1:0] PROT_BASE = UC_PROT_BASE
`endif
) (
    input  logic              clk,
    input  logic              arst_n,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_err,

    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic              last_gnt;
    logic              any_gnt;
    logic              wprot_hit;
    logic              access;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    rtag_t             rd_tag_q;
    rtag_t             cap_tag;

    // Grant: a lone requester always wins; on a tie the port that did not win last goes
    always_comb begin
        cpu_gnt  = cpu_req && (!host_req || (last_gnt == PORT_HOST));
        host_gnt = host_req && !cpu_gnt;
        any_gnt  = cpu_gnt || host_gnt;
    end

    // Route the granted port's fields toward the SRAM registers
    always_comb begin
        sel_we    = host_gnt ? host_we    : cpu_we;
        sel_addr  = host_gnt ? host_addr  : cpu_addr;
        sel_wdata = host_gnt ? host_wdata : cpu_wdata;
    end

`ifdef SRAM_ARB_WPROT_EN
    // HOST writes into the protected top region are consumed but never reach the SRAM
    assign wprot_hit = host_gnt && host_we && (host_addr >= PROT_BASE);

    // Flag each swallowed protected write in the cycle its access would have run
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            host_err <= 1'b0;
        end else begin
            host_err <= wprot_hit;
        end
    end
`else
    assign wprot_hit = 1'b0;
    assign host_err  = 1'b0;
`endif

    assign access = any_gnt && !wprot_hit;

    // Round-robin pointer moves only when someone is granted, blocked writes included
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_gnt <= PORT_HOST;
        end else if (any_gnt) begin
            last_gnt <= host_gnt ? PORT_HOST : PORT_CPU;
        end
    end

    // Launch the SRAM access one cycle after the grant; address/data hold when idle
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            sram_en <= access;
            sram_we <= access && sel_we;
            if (access) begin
                sram_addr  <= sel_addr;
                sram_wdata <= sel_wdata;
            end
        end
    end

    // Read tag launched alongside sram_en so it enters the return pipe at N+1
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_tag_q <= '0;
        end else begin
            rd_tag_q.valid <= access && !sel_we;
            rd_tag_q.owner <= host_gnt ? PORT_HOST : PORT_CPU;
        end
    end

    sram_arb_rpipe #(
        .RD_LAT (RD_LAT)
    ) u_rpipe (
        .clk     (clk),
        .arst_n  (arst_n),
        .tag_in  (rd_tag_q),
        .tag_out (cap_tag)
    );

    // Capture returning data into the owner's register; the other port keeps its value
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_rdata   <= '0;
            host_rdata  <= '0;
        end else begin
            cpu_rvalid  <= cap_tag.valid && (cap_tag.owner == PORT_CPU);
            host_rvalid <= cap_tag.valid && (cap_tag.owner == PORT_HOST);
            if (cap_tag.valid && (cap_tag.owner == PORT_CPU)) begin
                cpu_rdata <= sram_rdata;
            end
            if (cap_tag.valid && (cap_tag.owner == PORT_HOST)) begin
                host_rdata <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed-vector bench for sram_arbiter (RD_LAT=1 and RD_LAT=2 instances)
module tb_sram_arbiter;

    logic       clk;
    logic       arst_n;

    logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       host_req, host_we, host_gnt, host_rvalid, host_err;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       sram_en, sram_we;
    logic [7:0] sram_addr, sram_wdata, sram_rdata;

    logic       b_cpu_req, b_cpu_we, b_cpu_gnt, b_cpu_rvalid;
    logic [7:0] b_cpu_addr, b_cpu_wdata, b_cpu_rdata;
    logic       b_host_req, b_host_we, b_host_gnt, b_host_rvalid, b_host_err;
    logic [7:0] b_host_addr, b_host_wdata, b_host_rdata;
    logic       b_sram_en, b_sram_we;
    logic [7:0] b_sram_addr, b_sram_wdata, b_sram_rdata;

    logic       l1_en, l2_en;
    logic [7:0] l1_addr, l1_data, l2_addr, l2_data;
    logic [7:0] mem1 [256];
    logic [7:0] mem2 [256];
    logic [7:0] rd2_q;

    int n_vec = 0;
    int n_err = 0;

    sram_arbiter #(.RD_LAT(1)) u_dut (
        .clk(clk), .arst_n(arst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    sram_arbiter #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .arst_n(arst_n),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
        .host_req(b_host_req), .host_we(b_host_we), .host_addr(b_host_addr), .host_wdata(b_host_wdata),
        .host_gnt(b_host_gnt), .host_rvalid(b_host_rvalid), .host_rdata(b_host_rdata), .host_err(b_host_err),
        .sram_en(b_sram_en), .sram_we(b_sram_we), .sram_addr(b_sram_addr), .sram_wdata(b_sram_wdata),
        .sram_rdata(b_sram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model, one-cycle read latency
    always @(posedge clk) begin
        if (l1_en) begin
            mem1[l1_addr] <= l1_data;
        end else if (sram_en && sram_we) begin
            mem1[sram_addr] <= sram_wdata;
        end
        if (sram_en && !sram_we) begin
            sram_rdata <= mem1[sram_addr];
        end
    end

    // SRAM model, two-cycle read latency
    always @(posedge clk) begin
        if (l2_en) begin
            mem2[l2_addr] <= l2_data;
        end else if (b_sram_en && b_sram_we) begin
            mem2[b_sram_addr] <= b_sram_wdata;
        end
        if (b_sram_en && !b_sram_we) begin
            rd2_q <= mem2[b_sram_addr];
        end
        b_sram_rdata <= rd2_q;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        l1_en = 1'b1; l1_addr = a; l1_data = d;
        @(negedge clk);
        l1_en = 1'b0;
    endtask

    task automatic load2(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        l2_en = 1'b1; l2_addr = a; l2_data = d;
        @(negedge clk);
        l2_en = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        #1;
        chk({tag, "_gnt"}, host_gnt, 1);
        step();
        host_req = 1'b0;
        step();
        chk({tag, "_rvalid_early"}, host_rvalid, 0);
        step();
        chk({tag, "_rvalid"}, host_rvalid, 1);
        chk({tag, "_rdata"}, host_rdata, exp);
    endtask

    task automatic host_write(input string tag, input logic [7:0] a, input logic [7:0] d,
                              input logic exp_en, input logic exp_err);
        @(negedge clk);
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        #1;
        chk({tag, "_gnt"}, host_gnt, 1);
        step();
        host_req = 1'b0; host_we = 1'b0;
        chk({tag, "_sram_en"}, sram_en, exp_en);
        chk({tag, "_sram_we"}, sram_we, exp_en);
        chk({tag, "_err"}, host_err, exp_err);
        step();
        chk({tag, "_err_clr"}, host_err, 0);
    endtask

    initial begin
        arst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
        b_host_req = 0; b_host_we = 0; b_host_addr = 0; b_host_wdata = 0;
        l1_en = 0; l1_addr = 0; l1_data = 0;
        l2_en = 0; l2_addr = 0; l2_data = 0;
        rd2_q = 0;

        load1(8'h01, 8'h11);
        load1(8'h02, 8'h22);
        load1(8'hF4, 8'h9A);
        load1(8'hEF, 8'h00);
        load2(8'h20, 8'hA5);
        #1;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_host_gnt", host_gnt, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_host_rvalid", host_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_host_err", host_err, 0);
        chk("rst_sram_en", sram_en, 0);
        chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_addr", sram_addr, 0);
        chk("rst_sram_wdata", sram_wdata, 0);
        @(negedge clk);
        arst_n = 1'b1;

        // CPU write 3C -> 10, then read it back
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'h3C;
        #1;
        chk("t1_wr_cpu_gnt", cpu_gnt, 1);
        chk("t1_wr_host_gnt", host_gnt, 0);
        step();
        cpu_req = 0; cpu_we = 0;
        chk("t1_wr_sram_en", sram_en, 1);
        chk("t1_wr_sram_we", sram_we, 1);
        chk("t1_wr_sram_addr", sram_addr, 8'h10);
        chk("t1_wr_sram_wdata", sram_wdata, 8'h3C);
        step();
        chk("t1_wr_no_rvalid", cpu_rvalid, 0);
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        #1;
        chk("t1_rd_cpu_gnt", cpu_gnt, 1);
        step();
        cpu_req = 0;
        chk("t1_rd_sram_en", sram_en, 1);
        chk("t1_rd_sram_we", sram_we, 0);
        step();
        chk("t1_rd_rvalid_n2", cpu_rvalid, 0);
        step();
        chk("t1_rd_rvalid_n3", cpu_rvalid, 1);
        chk("t1_rd_rdata", cpu_rdata, 8'h3C);
        chk("t1_rd_host_rvalid", host_rvalid, 0);
        step();
        chk("t1_rd_rvalid_pulse", cpu_rvalid, 0);

        // Reset one cycle after a CPU read grant
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        #1;
        chk("t5_cpu_gnt", cpu_gnt, 1);
        step();
        cpu_req = 0;
        arst_n = 1'b0;
        #1;
        chk("t5_sram_en", sram_en, 0);
        chk("t5_sram_addr", sram_addr, 0);
        chk("t5_cpu_rdata", cpu_rdata, 0);
        chk("t5_cpu_rvalid", cpu_rvalid, 0);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t5_no_rvalid", cpu_rvalid, 0);
        end

        // Tie for 4 cycles: CPU, HOST, CPU, HOST with returns in order
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
                host_req = 1; host_we = 0; host_addr = 8'h02;
            end
            if (i == 4) begin
                cpu_req = 0; host_req = 0;
            end
            #1;
            if (i < 4) begin
                chk("t2_cpu_gnt", cpu_gnt, (i % 2 == 0) ? 1 : 0);
                chk("t2_host_gnt", host_gnt, (i % 2 == 1) ? 1 : 0);
            end
            if (i >= 3 && i <= 6) begin
                chk("t2_cpu_rvalid", cpu_rvalid, ((i - 3) % 2 == 0) ? 1 : 0);
                chk("t2_host_rvalid", host_rvalid, ((i - 3) % 2 == 1) ? 1 : 0);
                if ((i - 3) % 2 == 0) chk("t2_cpu_rdata", cpu_rdata, 8'h11);
                else chk("t2_host_rdata", host_rdata, 8'h22);
            end
            if (i == 3) chk("t2_host_rdata_hold0", host_rdata, 0);
            if (i == 5) chk("t2_host_rdata_hold", host_rdata, 8'h22);
            if (i == 7) begin
                chk("t2_cpu_rvalid_end", cpu_rvalid, 0);
                chk("t2_host_rvalid_end", host_rvalid, 0);
            end
        end

        // HOST drops its write while CPU holds priority: only the CPU access happens
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h01;
        host_req = 1; host_we = 1; host_addr = 8'h02; host_wdata = 8'h77;
        #1;
        chk("t6_cpu_gnt", cpu_gnt, 1);
        chk("t6_host_gnt", host_gnt, 0);
        step();
        cpu_req = 0; host_req = 0; host_we = 0;
        chk("t6_sram_en", sram_en, 1);
        chk("t6_sram_addr", sram_addr, 8'h01);
        step();
        chk("t6_sram_idle", sram_en, 0);
        step();
        chk("t6_sram_idle2", sram_en, 0);
        chk("t6_cpu_rvalid", cpu_rvalid, 1);
        chk("t6_cpu_rdata", cpu_rdata, 8'h11);
        chk("t6_host_rvalid", host_rvalid, 0);
        host_read("t6_rd02", 8'h02, 8'h22);

`ifdef SRAM_ARB_WPROT_EN
        host_write("t4_prot", 8'hF4, 8'h55, 1'b0, 1'b1);
        host_read("t4_prot_rd", 8'hF4, 8'h9A);
        host_write("t4_open", 8'hEF, 8'h55, 1'b1, 1'b0);
        host_read("t4_open_rd", 8'hEF, 8'h55);
`else
        host_write("t4_wr", 8'hF4, 8'h55, 1'b1, 1'b0);
        host_read("t4_rd", 8'hF4, 8'h55);
`endif

        // RD_LAT=2 instance: HOST read of 20 returns A5 four cycles after grant
        @(negedge clk);
        b_host_req = 1; b_host_we = 0; b_host_addr = 8'h20;
        #1;
        chk("t3_gnt", b_host_gnt, 1);
        step();
        b_host_req = 0;
        chk("t3_sram_en", b_sram_en, 1);
        step();
        chk("t3_rvalid_n2", b_host_rvalid, 0);
        step();
        chk("t3_rvalid_n3", b_host_rvalid, 0);
        step();
        chk("t3_rvalid_n4", b_host_rvalid, 1);
        chk("t3_rdata", b_host_rdata, 8'hA5);
        chk("t3_cpu_rvalid", b_cpu_rvalid, 0);
        step();
        chk("t3_rvalid_pulse", b_host_rvalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port 256x8 data SRAM between two requesters: the CPU control unit (port CPU) and the external host/debug loader (port HOST).
- Round-robin arbitration; one access granted per cycle.
- Read data is returned to the owning port through a tagged return pipeline.
- Sits between the control unit, the host interface and the data SRAM macro.

Parameters:
ADDR_W, 8, SRAM address width.
DATA_W, 8, SRAM data width.
RD_LAT, 1, SRAM read latency in cycles, from sram_en to sram_rdata valid; legal values 1 or 2.
PROT_BASE, 8'hF0, lowest write-protected address for HOST. Used only with SRAM_ARB_WPROT_EN.

Ports:
clk  in  1  clock, rising edge.
arst_n  in  1  reset, asynchronous, active-low.
cpu_req  in  1  CPU access request; held with its fields until cpu_gnt.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W  access address.
cpu_wdata  in  DATA_W  write data.
cpu_gnt  out  1  combinational grant; the transfer occurs in a cycle where req and gnt are both 1.
cpu_rvalid  out  1  one-cycle pulse; cpu_rdata valid.
cpu_rdata  out  DATA_W  read data, registered.
host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same as the cpu_* ports, for HOST.
host_err  out  1  one-cycle pulse on a blocked protected write; constant 0 without the macro.
sram_en  out  1  SRAM access strobe, registered.
sram_we  out  1  SRAM write enable, registered.
sram_addr  out  ADDR_W  SRAM address, registered.
sram_wdata  out  DATA_W  SRAM write data, registered.
sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after sram_en on a read.

Behaviour:
- Reset values: all outputs 0; round-robin pointer last_gnt = HOST, so CPU wins the first tie; return pipeline empty.
- Arbitration in cycle N:
  - Only one req high: that port is granted regardless of the pointer.
  - Both high: the port not equal to last_gnt is granted.
  - Neither high: no grant.
  - At most one gnt per cycle; gnt is never high without its req.
- last_gnt updates only in a cycle with a grant.
- Cycle N+1: sram_en = 1, and sram_we/sram_addr/sram_wdata are the granted port's fields. Without a grant, sram_en = 0 and sram_we = 0; sram_addr and sram_wdata hold their last values.
- Reads:
  - Tag {valid, owner} enters the return pipeline, sram_arb_rpipe, at N+1.
  - At N+1+RD_LAT, sram_rdata is captured into the owner's rdata register.
  - The owner's rvalid pulses at N+2+RD_LAT: 3 cycles after grant for RD_LAT=1.
  - The other port's rdata holds its previous value.
- Writes: complete at N+1; no rvalid.
- Throughput: one grant per cycle sustained; back-to-back reads from alternating ports return in grant order without bubbles.
- Simultaneous read return and new grant in the same cycle: both are handled independently.
- A requester dropping req before gnt: no access; not an error.
- Reset mid-operation: in-flight tags are flushed and no rvalid issues for them; the pointer returns to its reset value.

Optional Feature:
- Macro SRAM_ARB_WPROT_EN.
- Enabled, HOST write with host_addr >= PROT_BASE:
  - host_gnt is still given, so the request is consumed.
  - sram_en stays 0 in N+1.
  - host_err pulses in N+1.
  - The pointer updates as for a normal grant.
- HOST reads and all CPU accesses are never blocked.
- Disabled: all writes proceed; host_err is tied 0.

Decomposition:
- Shared package uc_pkg:
  - ADDR_W and DATA_W defaults.
  - Port ID constants PORT_CPU = 1'b0, PORT_HOST = 1'b1.
  - Default PROT_BASE.
- Sub-module sram_arb_rpipe:
  - RD_LAT-deep shift register of {valid, owner}.
  - Flush on reset.
  - Output strobes the capture cycle.

Test Plan:
- CPU write 8'h3C to 8'h10, then CPU read of 8'h10 -> cpu_gnt the same cycle as each req; sram_we = 1 at N+1; cpu_rvalid 3 cycles after the read grant with cpu_rdata = 8'h3C; host_rvalid stays 0.
- Both req held high for 4 cycles, reads of 8'h01 (CPU) and 8'h02 (HOST) -> grants CPU, HOST, CPU, HOST; rvalids alternate with the correct data per port.
- RD_LAT=2 build, HOST read of 8'h20 containing 8'hA5 -> host_rvalid 4 cycles after grant, host_rdata = 8'hA5.
- SRAM_ARB_WPROT_EN, HOST write 8'h55 to 8'hF4 -> host_gnt = 1; sram_en = 0 at N+1; host_err pulse; a later read of 8'hF4 returns the old value. Same write to 8'hEF -> written, no host_err.
- arst_n asserted one cycle after a CPU read grant -> all outputs 0; no cpu_rvalid follows; the next tie grants CPU.
- HOST req high, then dropped before grant while CPU holds priority -> no HOST access; sram_en only for CPU transfers.
